// File: rtl/aemb_iprefetch.sv
// AEMB instruction prefetch queue: single-outstanding Wishbone fetcher feeding a FWFT FIFO.
// Optional combinational ack-to-output forwarding when AEMB_IPF_BYPASS_EN is defined.
module aemb_iprefetch #(
    parameter int unsigned AW      = 2,
    parameter logic [29:0] RST_VEC = 30'h0
) (
    input  logic        gclk,
    input  logic        grst,
    input  logic        gena,
    input  logic        bra_i,
    input  logic [29:0] bra_adr_i,
    output logic        iwb_stb_o,
    output logic [29:0] iwb_adr_o,
    input  logic [31:0] iwb_dat_i,
    input  logic        iwb_ack_i,
    output logic        ins_vld_o,
    output logic [31:0] ins_dat_o,
    output logic [29:0] ins_pc_o
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [31:0] NOP = 32'h80000000;

    typedef enum logic [1:0] {StIdle, StFetch, StDiscard} state_e;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [29:0]   r_pc;
    logic [29:0]   r_adr;
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_wptr;
    logic [AW:0]   r_cnt;
    logic [AW:0]   w_cnt_nxt;
    logic [31:0]   r_dat [DEPTH];
    logic [29:0]   r_ipc [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_fetch_ack;
    logic w_byp;
    logic w_push;
    logic w_pop;

    assign w_empty     = (r_cnt == '0);
    assign w_full      = r_cnt[AW];
    assign w_fetch_ack = (r_state == StFetch) && iwb_ack_i;

`ifdef AEMB_IPF_BYPASS_EN
    assign w_byp = w_fetch_ack && !bra_i && w_empty;
`else
    assign w_byp = 1'b0;
`endif

    // A forwarded word consumed in the same cycle never enters the FIFO.
    assign w_push = w_fetch_ack && !bra_i && !(w_byp && gena);
    assign w_pop  = gena && !w_empty && !bra_i;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + 1'b1;
            2'b01:   w_cnt_nxt = r_cnt - 1'b1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:    if (!bra_i && !w_full) w_state_nxt = StFetch;
            StFetch: begin
                if (iwb_ack_i)  w_state_nxt = StIdle;
                else if (bra_i) w_state_nxt = StDiscard;
            end
            StDiscard: if (iwb_ack_i) w_state_nxt = StIdle;
            default:   w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            r_state <= StIdle;
            r_pc    <= RST_VEC;
            r_adr   <= RST_VEC;
            r_cnt   <= '0;
            r_rptr  <= '0;
            r_wptr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Latch the fetch address so a redirect during a read leaves the bus stable.
            if (r_state == StIdle) r_adr <= r_pc;
            if (bra_i)            r_pc <= bra_adr_i;
            else if (w_fetch_ack) r_pc <= r_pc + 30'd1;
            if (bra_i) begin
                r_cnt  <= '0;
                r_rptr <= '0;
                r_wptr <= '0;
            end else begin
                r_cnt <= w_cnt_nxt;
                if (w_push) r_wptr <= r_wptr + AW'(1);
                if (w_pop)  r_rptr <= r_rptr + AW'(1);
            end
        end
    end

    always_ff @(posedge gclk) begin
        if (w_push) begin
            r_dat[r_wptr] <= iwb_dat_i;
            r_ipc[r_wptr] <= r_pc;
        end
    end

    assign iwb_stb_o = (r_state != StIdle);
    assign iwb_adr_o = (r_state == StIdle) ? r_pc : r_adr;

    always_comb begin
        ins_vld_o = 1'b0;
        ins_dat_o = NOP;
        ins_pc_o  = '0;
        if (!w_empty) begin
            ins_vld_o = 1'b1;
            ins_dat_o = r_dat[r_rptr];
            ins_pc_o  = r_ipc[r_rptr];
        end else if (w_byp) begin
            ins_vld_o = 1'b1;
            ins_dat_o = iwb_dat_i;
            ins_pc_o  = r_pc;
        end
    end

endmodule
